md_unit: RTL
============

Name: md_unit

Overview:
- E-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Sits beside the ALU and takes the same forwarded operands: rs value on A, and on B the output of the ALU-B operand select.
- Runs MULT/MULTU/DIV/DIVU over a fixed number of cycles and handles MTHI/MTLO.
- Holds the architectural HI/LO registers, which MFHI/MFLO read, and drives a busy flag that the hazard unit uses to stall D.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  one-cycle request to begin md_op with the current A and B
md_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others are no-ops
A  input  32  operand 1 (rs value, forwarded)
B  input  32  operand 2 (rt value, forwarded)
busy  output  1  high while a multiply or divide is in flight
hi  output  32  architectural HI register
lo  output  32  architectural LO register

Behaviour:
- Reset (synchronous): hi=0, lo=0, busy=0, counter=0, state IDLE. Reset wins over start in the same cycle. Reset during RUN aborts the operation; its result is never written.
- States:
  - IDLE: accepts start.
  - RUN: counter counts down.
- IDLE with start and md_op in {MULT, MULTU, DIV, DIVU}, at the edge:
  - latch A and B;
  - compute the result into shadow registers (combinational compute at start is acceptable);
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - busy=1; go to RUN.
- RUN: counter decrements each edge. At the edge where the counter reaches 0:
  - copy shadow to hi/lo;
  - busy=0; go to IDLE.
  - Net effect: busy is high for exactly N cycles after the start edge, and the new hi/lo are visible on the same edge busy falls.
- MTHI/MTLO with start in IDLE: write A into hi (MTHI) or lo (MTLO) at that edge. busy stays 0, and lo (or hi) is untouched.
- start while busy=1: ignored, with no effect on the in-flight operation. The hazard unit must stall any MD-class instruction in D while (start_E | busy); md_unit does not check this.
- start with an undefined md_op: no-op.
- Arithmetic:
  - MULT: {hi,lo} = signed(A) * signed(B), full 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - DIVU: lo = unsigned quotient; hi = unsigned remainder.
  - DIV/DIVU with B == 0: full busy latency; hi and lo keep their old values.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wraps, no trap).
- Operand capture: A and B are sampled only at the start edge. Later changes on A/B (forwarding updates, bubbles) do not affect the result.
- No flush input. An MD instruction that reaches E always completes, which matches the no-exception P5 scope.
- hi, lo and busy are driven directly from registers, with no combinational path from the inputs.

Test Plan:
1. Signed multiply
   - Stimulus: reset, then start MULT with A=0xFFFFFFFE (-2), B=0x00000003.
   - Response: busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, on the edge busy drops.
2. Unsigned multiply
   - Stimulus: MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF.
   - Response: after 5 cycles, hi=0xFFFFFFFE, lo=0x00000001.
3. Signed divide
   - Stimulus: DIV with A=0xFFFFFFF9 (-7), B=2.
   - Response: busy for 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
   - Follow-up: DIVU with A=7, B=2 gives lo=3, hi=1.
4. Divide by zero, then start while busy
   - Stimulus: preload hi=0x11 and lo=0x22 via MTHI/MTLO, each taking effect the next edge with busy=0. Then DIV with B=0.
   - Response: after 10 cycles, hi=0x11 and lo=0x22 unchanged.
   - Stimulus: during that run, assert start MULT with A=3, B=3 at busy cycle 4.
   - Response: the MULT is ignored, and hi/lo remain 0x11/0x22 after busy falls.
5. Operand capture and reset abort
   - Stimulus: start MULT with A=5, B=6, then change A/B every cycle during busy.
   - Response: lo=30, hi=0.
   - Stimulus: start DIV with A=100, B=7, and assert reset on busy cycle 3.
   - Response: next edge busy=0, hi=0, lo=0, and no later write occurs.
6. MTLO interaction and reset priority
   - Stimulus: after a MULT completes, issue MTLO with A=0xABCD.
   - Response: lo=0xABCD next edge and hi is retained.
   - Stimulus: assert start together with reset.
   - Response: nothing starts.

Source files
------------

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - request/result bundle between the E stage and the multiply/divide unit
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, md_op, A, B, input busy, hi, lo);
    modport slave  (input start, md_op, A, B, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multiply/divide unit holding the architectural HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic [31:0]   r_hi, r_lo;
    logic [31:0]   r_sh_hi, r_sh_lo;
    logic          r_sh_we;

    logic [63:0]   w_prod;
    logic [31:0]   w_a_mag, w_b_mag, w_b_div, w_uq, w_ur;
    logic [31:0]   w_res_hi, w_res_lo;
    logic          w_res_we;
    logic          w_is_div;

    // Signed division goes through magnitudes so INT_MIN / -1 wraps cleanly.
    always_comb begin
        w_prod   = 64'd0;
        w_a_mag  = bus.A;
        w_b_mag  = bus.B;
        w_b_div  = 32'd1;
        w_uq     = 32'd0;
        w_ur     = 32'd0;
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_we = 1'b1;
        w_is_div = (bus.md_op == OP_DIV) || (bus.md_op == OP_DIVU);
        if (bus.md_op == OP_DIV) begin
            w_a_mag = bus.A[31] ? -bus.A : bus.A;
            w_b_mag = bus.B[31] ? -bus.B : bus.B;
        end
        w_b_div = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
        w_uq    = w_a_mag / w_b_div;
        w_ur    = w_a_mag % w_b_div;
        case (bus.md_op)
            OP_MULT: begin
                w_prod = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
                {w_res_hi, w_res_lo} = w_prod;
            end
            OP_MULTU: begin
                w_prod = {32'd0, bus.A} * {32'd0, bus.B};
                {w_res_hi, w_res_lo} = w_prod;
            end
            OP_DIV: begin
                w_res_lo = (bus.A[31] ^ bus.B[31]) ? -w_uq : w_uq;
                w_res_hi = bus.A[31] ? -w_ur : w_ur;
                w_res_we = (bus.B != 32'd0);
            end
            OP_DIVU: begin
                w_res_lo = w_uq;
                w_res_hi = w_ur;
                w_res_we = (bus.B != 32'd0);
            end
            default: w_res_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_sh_hi <= 32'd0;
            r_sh_lo <= 32'd0;
            r_sh_we <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.md_op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_sh_hi <= w_res_hi;
                                r_sh_lo <= w_res_lo;
                                r_sh_we <= w_res_we;
                                r_cnt   <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                                r_busy  <= 1'b1;
                                r_state <= S_RUN;
                            end
                            OP_MTHI: r_hi <= bus.A;
                            OP_MTLO: r_lo <= bus.A;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        if (r_sh_we) begin
                            r_hi <= r_sh_hi;
                            r_lo <= r_sh_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
